// File: rtl/axi_csr_irq_ctrl.sv
// Router CSR block with per-VC edge-triggered interrupts; one response per request, exactly 1 cycle later.
// Never backpressures (req_ready tied high); back-to-back requests each get their own response.
module axi_csr_irq_ctrl #(
  parameter int unsigned ROUTER_X_ID = 0,
  parameter int unsigned ROUTER_Y_ID = 0,
  parameter int          N_VC        = 3,
  parameter logic [31:0] VERSION     = 32'h0002_0000,
  parameter int          ADDR_W      = 8
) (
  input  logic               clk_axi,
  input  logic               arst_axi,
  input  logic               req_valid,
  input  logic               req_wr,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [31:0]        req_wdata,
  output logic               req_ready,
  output logic               resp_valid,
  output logic               resp_error,
  output logic [31:0]        resp_rdata,
  input  logic [N_VC-1:0]    empty_rd_bff_i,
  input  logic [N_VC-1:0]    full_rd_bff_i,
  input  logic [N_VC*16-1:0] fifo_ocup_rd_bff_i,
  output logic [N_VC-1:0]    irq_vcs_o,
  output logic               irq_o
);

  localparam logic [ADDR_W-1:0] A_VERSION  = ADDR_W'(32'h00);
  localparam logic [ADDR_W-1:0] A_ROUTER_X = ADDR_W'(32'h04);
  localparam logic [ADDR_W-1:0] A_ROUTER_Y = ADDR_W'(32'h08);
  localparam logic [ADDR_W-1:0] A_IRQ_RAW  = ADDR_W'(32'h0C);
  localparam logic [ADDR_W-1:0] A_IRQ_PEND = ADDR_W'(32'h10);
  localparam logic [ADDR_W-1:0] A_IRQ_MASK = ADDR_W'(32'h14);
  localparam logic [ADDR_W-1:0] A_IRQ_MODE = ADDR_W'(32'h18);
  localparam logic [ADDR_W-1:0] A_ERR_CNT  = ADDR_W'(32'h1C);

  logic [N_VC-1:0] r_pend;
  logic [N_VC-1:0] r_mask;
  logic [N_VC-1:0] r_mode;
  logic [N_VC-1:0] r_src_ff;
  logic [N_VC-1:0] r_irq_vcs;
  logic            r_irq;
  logic [15:0]     r_err_cnt;
  logic            r_resp_vld;
  logic            r_resp_err;
  logic [31:0]     r_resp_rdata;

  logic            w_hit;
  logic            w_ro;
  logic [31:0]     w_rdata;
  logic            w_err;
  logic            w_wr_ok;
  logic [N_VC-1:0] w_src;
  logic [N_VC-1:0] w_rise;
  logic [N_VC-1:0] w_clr;
  logic [N_VC-1:0] w_pend_nxt;
  logic [N_VC-1:0] w_mask_nxt;
  logic            w_unused;

  assign w_unused = ^req_wdata[31:N_VC];

  assign w_src  = (r_mode & full_rd_bff_i) | (~r_mode & ~empty_rd_bff_i);
  assign w_rise = w_src & ~r_src_ff;

  always_comb begin
    w_hit   = 1'b0;
    w_ro    = 1'b0;
    w_rdata = '0;
    case (req_addr)
      A_VERSION:  begin w_hit = 1'b1; w_ro = 1'b1; w_rdata = VERSION; end
      A_ROUTER_X: begin w_hit = 1'b1; w_ro = 1'b1; w_rdata = 32'(ROUTER_X_ID); end
      A_ROUTER_Y: begin w_hit = 1'b1; w_ro = 1'b1; w_rdata = 32'(ROUTER_Y_ID); end
      A_IRQ_RAW:  begin w_hit = 1'b1; w_ro = 1'b1; w_rdata = 32'(w_src); end
      A_IRQ_PEND: begin w_hit = 1'b1; w_rdata = 32'(r_pend); end
      A_IRQ_MASK: begin w_hit = 1'b1; w_rdata = 32'(r_mask); end
      A_IRQ_MODE: begin w_hit = 1'b1; w_rdata = 32'(r_mode); end
      A_ERR_CNT:  begin w_hit = 1'b1; w_ro = 1'b1; w_rdata = {16'h0, r_err_cnt}; end
      default:    ;
    endcase
    for (int i = 0; i < N_VC; i++) begin
      if (req_addr == ADDR_W'(32'h20 + 32'(4 * i))) begin
        w_hit   = 1'b1;
        w_ro    = 1'b1;
        w_rdata = {16'h0, fifo_ocup_rd_bff_i[16*i +: 16]};
      end
    end
  end

  // ERR_CNT is read-only but its write (any data) is the clear command, not an error.
  assign w_err   = (req_addr[1:0] != 2'b00) | ~w_hit | (req_wr & w_ro & (req_addr != A_ERR_CNT));
  assign w_wr_ok = req_valid & req_wr & ~w_err;
  assign w_clr   = (w_wr_ok && req_addr == A_IRQ_PEND) ? req_wdata[N_VC-1:0] : '0;

  // Set wins over W1C clear when both land in the same cycle.
  assign w_pend_nxt = (r_pend & ~w_clr) | w_rise;
  assign w_mask_nxt = (w_wr_ok && req_addr == A_IRQ_MASK) ? req_wdata[N_VC-1:0] : r_mask;

  always_ff @(posedge clk_axi or posedge arst_axi) begin
    if (arst_axi) begin
      r_pend       <= '0;
      r_mask       <= '0;
      r_mode       <= '0;
      r_src_ff     <= '0;
      r_irq_vcs    <= '0;
      r_irq        <= 1'b0;
      r_err_cnt    <= '0;
      r_resp_vld   <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_src_ff  <= w_src;
      r_pend    <= w_pend_nxt;
      r_mask    <= w_mask_nxt;
      r_irq_vcs <= w_pend_nxt & w_mask_nxt;
      r_irq     <= |(w_pend_nxt & w_mask_nxt);
      if (w_wr_ok && req_addr == A_IRQ_MODE) r_mode <= req_wdata[N_VC-1:0];
      if (w_wr_ok && req_addr == A_ERR_CNT) begin
        r_err_cnt <= '0;
      end else if (req_valid && w_err && r_err_cnt != 16'hFFFF) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
      r_resp_vld   <= req_valid;
      r_resp_err   <= req_valid & w_err;
      r_resp_rdata <= (req_valid && !req_wr && !w_err) ? w_rdata : '0;
    end
  end

  assign req_ready  = 1'b1;
  assign resp_valid = r_resp_vld;
  assign resp_error = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign irq_vcs_o  = r_irq_vcs;
  assign irq_o      = r_irq;

endmodule

// File: tb/tb_axi_csr_irq_ctrl.sv
// Randomized and directed bench for axi_csr_irq_ctrl against a behavioural register-map model.
module tb_axi_csr_irq_ctrl;

  localparam int NV = 3;

  logic        clk_axi = 1'b0;
  logic        arst_axi;
  logic        req_valid, req_wr;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        req_ready, resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic [NV-1:0]    empty_rd_bff_i, full_rd_bff_i;
  logic [NV*16-1:0] fifo_ocup_rd_bff_i;
  logic [NV-1:0]    irq_vcs_o;
  logic             irq_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int unsigned m_pend, m_mask, m_mode, m_prev, m_errcnt;

  axi_csr_irq_ctrl #(
    .ROUTER_X_ID(2), .ROUTER_Y_ID(1), .N_VC(NV), .VERSION(32'h0002_0000), .ADDR_W(8)
  ) dut (
    .clk_axi(clk_axi), .arst_axi(arst_axi),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_error(resp_error), .resp_rdata(resp_rdata),
    .empty_rd_bff_i(empty_rd_bff_i), .full_rd_bff_i(full_rd_bff_i),
    .fifo_ocup_rd_bff_i(fifo_ocup_rd_bff_i),
    .irq_vcs_o(irq_vcs_o), .irq_o(irq_o)
  );

  always #5 clk_axi = ~clk_axi;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_mapped(int a);
    if (a < 32) return 1'b1;
    return ((a - 32) / 4) < NV;
  endfunction

  function automatic bit is_ro(int a);
    return (a == 0 || a == 4 || a == 8 || a == 12 || a == 28 || a >= 32);
  endfunction

  function automatic int unsigned cur_src();
    int unsigned s = 0;
    for (int i = 0; i < NV; i++) begin
      if (((m_mode >> i) & 1) == 1) s += full_rd_bff_i[i] ? (1 << i) : 0;
      else                          s += empty_rd_bff_i[i] ? 0 : (1 << i);
    end
    return s;
  endfunction

  function automatic logic [31:0] model_read(int a, int unsigned src);
    case (a)
      0:  return 32'h0002_0000;
      4:  return 32'd2;
      8:  return 32'd1;
      12: return src;
      16: return m_pend;
      20: return m_mask;
      24: return m_mode;
      28: return m_errcnt;
      default: return {16'h0, fifo_ocup_rd_bff_i[16*((a-32)/4) +: 16]};
    endcase
  endfunction

  task automatic model_reset();
    m_pend = 0; m_mask = 0; m_mode = 0; m_prev = 0; m_errcnt = 0;
  endtask

  // One access cycle: drive, advance model by one clock, then compare the response and IRQs.
  task automatic acc(input bit v, input bit wr, input int addr, input logic [31:0] wd);
    int unsigned src, rise, clr, irq_exp;
    bit err;
    logic [31:0] rd;
    req_valid = v; req_wr = wr; req_addr = 8'(addr); req_wdata = wd;
    src = cur_src();
    err = v && ((addr % 4) != 0 || !is_mapped(addr) || (wr && is_ro(addr) && addr != 28));
    rd  = (v && !wr && !err) ? model_read(addr, src) : 32'h0;
    clr = 0;
    if (v && wr && !err) begin
      case (addr)
        16: clr      = wd & 7;
        20: m_mask   = wd & 7;
        24: m_mode   = wd & 7;
        28: m_errcnt = 0;
        default: ;
      endcase
    end
    if (err && m_errcnt < 65535) m_errcnt++;
    rise   = src & ~m_prev & 7;
    m_pend = ((m_pend & ~clr) | rise) & 7;
    m_prev = src;
    irq_exp = m_pend & m_mask;
    @(posedge clk_axi); #1;
    check("resp_valid", resp_valid, v);
    check("resp_error", resp_error, err);
    check("resp_rdata", resp_rdata, rd);
    check("irq_vcs_o",  irq_vcs_o,  irq_exp);
    check("irq_o",      irq_o,      irq_exp != 0);
    req_valid = 1'b0;
  endtask

  initial begin
    arst_axi = 1'b1;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    empty_rd_bff_i = 3'b110; full_rd_bff_i = 3'b000;
    fifo_ocup_rd_bff_i = {16'h0333, 16'h0222, 16'h0111};
    model_reset();
    #1;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_error", resp_error, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_irq_vcs",    irq_vcs_o,  0);
    check("rst_irq_o",      irq_o,      0);
    check("req_ready",      req_ready,  1);
    #11 arst_axi = 1'b0;

    // Source already high at release sets pend on the first edge.
    acc(0, 0, 0, 0);
    acc(1, 0, 16, 0);
    check("pend_after_release", resp_rdata, 32'h1);

    acc(1, 0, 0, 0); check("version", resp_rdata, 32'h0002_0000);
    acc(1, 0, 4, 0); check("router_x", resp_rdata, 32'd2);
    acc(1, 0, 8, 0); check("router_y", resp_rdata, 32'd1);
    acc(1, 0, 36, 0);
    acc(1, 0, 40, 0);

    acc(1, 1, 16, 1);
    empty_rd_bff_i = 3'b111;
    acc(1, 1, 20, 1);
    empty_rd_bff_i = 3'b110;
    acc(0, 0, 0, 0);
    check("irq_vc0", irq_vcs_o, 3'b001);
    acc(1, 1, 16, 1);
    check("irq_clr", irq_o, 0);

    // Rising edge on VC1 coincides with its W1C clear.
    empty_rd_bff_i = 3'b100;
    acc(1, 1, 16, 2);
    acc(1, 0, 16, 0);
    check("set_wins", resp_rdata[1], 1);

    acc(1, 1, 24, 4);
    full_rd_bff_i = 3'b100;
    acc(0, 0, 0, 0);
    check("masked_vc2", irq_vcs_o[2], 0);
    acc(1, 1, 20, 4);
    check("unmask_vc2", irq_vcs_o, 3'b100);

    acc(1, 1, 28, 0);
    acc(1, 1, 0, 32'h1234);
    acc(1, 0, 2, 0);
    acc(1, 0, 44, 0);
    acc(1, 0, 28, 0);
    check("err_cnt_3", resp_rdata, 3);
    acc(1, 1, 28, 32'hFFFF_FFFF);
    acc(1, 0, 28, 0);
    check("err_cnt_clr", resp_rdata, 0);

    for (int k = 0; k < 400; k++) begin
      int a;
      if ($urandom_range(0, 3) == 0) begin
        empty_rd_bff_i = 3'($urandom_range(0, 7));
        full_rd_bff_i  = 3'($urandom_range(0, 7));
        fifo_ocup_rd_bff_i = {16'($urandom), 16'($urandom), 16'($urandom)};
      end
      a = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : 4 * int'($urandom_range(0, 15));
      acc(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)), a, $urandom);
    end

    acc(1, 1, 28, 0);
    for (int k = 0; k < 65540; k++) acc(1, 0, 2, 0);
    acc(1, 0, 28, 0);
    check("err_cnt_sat", resp_rdata, 32'h0000_FFFF);

    // Reset while a request is on the bus, with all VCs pending and unmasked.
    acc(1, 1, 24, 0);
    empty_rd_bff_i = 3'b111; full_rd_bff_i = 3'b000;
    acc(1, 1, 20, 7);
    empty_rd_bff_i = 3'b000;
    acc(0, 0, 0, 0);
    check("pre_rst_irq", irq_vcs_o, 3'b111);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'h00;
    #3 arst_axi = 1'b1;
    #1;
    check("arst_resp_valid", resp_valid, 0);
    check("arst_resp_rdata", resp_rdata, 0);
    check("arst_irq_vcs",    irq_vcs_o,  0);
    check("arst_irq_o",      irq_o,      0);
    req_valid = 1'b0;
    @(posedge clk_axi); #1;
    arst_axi = 1'b0;
    model_reset();
    acc(0, 0, 0, 0);
    acc(0, 0, 0, 0);
    acc(1, 0, 20, 0);
    check("mask_after_rst", resp_rdata, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
